// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch inputs, writeback port and decoded outputs toward ID/EX.
// The master modport is the pipeline side that feeds and consumes the stage; slave is id_stage.
interface id_stage_if #(
  parameter int XLEN = 32
);
  // IF -> ID
  logic [31:0]     InstrF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCplus4F;
  // Hazard control
  logic            StallD;
  logic            FlushD;
  // Writeback port into the register file
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  // ID -> ID/EX
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCplus4D;
  logic [XLEN-1:0] RD1D;
  logic [XLEN-1:0] RD2D;
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic [4:0]      RdD;
  logic [XLEN-1:0] ImmExtD;
  logic            RegWriteD;
  logic [1:0]      ResultSrcD;
  logic            MemWriteD;
  logic            JumpD;
  logic            BranchD;
  logic            ALUSrcD;
  logic [2:0]      ALUControlD;
  logic            IllegalD;

  modport master (
    output InstrF, PCF, PCplus4F, StallD, FlushD, RegWriteW, RdW, ResultW,
    input  InstrD, PCD, PCplus4D, RD1D, RD2D, Rs1D, Rs2D, RdD, ImmExtD,
           RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ALUControlD, IllegalD
  );

  modport slave (
    input  InstrF, PCF, PCplus4F, StallD, FlushD, RegWriteW, RdW, ResultW,
    output InstrD, PCD, PCplus4D, RD1D, RD2D, Rs1D, Rs2D, RdD, ImmExtD,
           RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ALUControlD, IllegalD
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, 32x32 register file, main/ALU decoder, immediate generator.
// Optional macro ID_BYPASS_EN: writeback data is forwarded to RD1D/RD2D in the same cycle.
module id_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic   clk,
  input logic   reset,
  id_stage_if.slave bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10
  } alu_op_e;

  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] i, input imm_src_e src);
    logic [XLEN-1:0] imm;
    case (src)
      IMM_S:   imm = {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm = {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   imm = {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      default: imm = {{(XLEN-12){i[31]}}, i[31:20]};
    endcase
    return imm;
  endfunction

  // Subtract only for R-type funct7[5]; I-type immediates may legitimately set bit 30.
  function automatic logic [2:0] alu_dec(input alu_op_e op, input logic [2:0] funct3,
                                         input logic op5, input logic funct7_5);
    logic [2:0] ctl;
    ctl = ALU_ADD;
    case (op)
      ALUOP_ADD: ctl = ALU_ADD;
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000:  ctl = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  ctl = ALU_SLT;
          3'b110:  ctl = ALU_OR;
          3'b111:  ctl = ALU_AND;
          default: ctl = ALU_ADD;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  logic [31:0]     instr_q,  instr_d;
  logic [XLEN-1:0] pc_q,     pc_d;
  logic [XLEN-1:0] pc4_q,    pc4_d;
  logic [XLEN-1:0] rf_q [32];

  logic [4:0]      rs1, rs2, rd;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rd1, rd2;

  imm_src_e        imm_src;
  alu_op_e         alu_op;
  logic            reg_write;
  logic [1:0]      result_src;
  logic            mem_write;
  logic            jump;
  logic            branch;
  logic            alu_src;
  logic            illegal;

  // IF/ID pipeline register: flush has priority over stall
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    if (bus.FlushD) begin
      instr_d = NOP_INSTR;
      pc_d    = '0;
      pc4_d   = '0;
    end else if (!bus.StallD) begin
      instr_d = bus.InstrF;
      pc_d    = bus.PCF;
      pc4_d   = bus.PCplus4F;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
    end
  end

  // Register file: entry 0 is never written so x0 stays hard-wired to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (bus.RegWriteW && (bus.RdW == 5'(i))) begin
          rf_q[i] <= bus.ResultW;
        end
      end
    end
  end

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign rd     = instr_q[11:7];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];

  always_comb begin
    rd1 = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    rd2 = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`ifdef ID_BYPASS_EN
    if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == rs1)) rd1 = bus.ResultW;
    if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == rs2)) rd2 = bus.ResultW;
`endif
  end

  // Main decoder
  always_comb begin
    reg_write  = 1'b0;
    imm_src    = IMM_I;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = RES_ALU;
    branch     = 1'b0;
    alu_op     = ALUOP_ADD;
    jump       = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP_LOAD: begin
        reg_write  = 1'b1;
        imm_src    = IMM_I;
        alu_src    = 1'b1;
        result_src = RES_MEM;
      end
      OP_STORE: begin
        mem_write = 1'b1;
        imm_src   = IMM_S;
        alu_src   = 1'b1;
      end
      OP_RTYPE: begin
        reg_write = 1'b1;
        alu_op    = ALUOP_FUNC;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        imm_src   = IMM_I;
        alu_src   = 1'b1;
        alu_op    = ALUOP_FUNC;
      end
      OP_BEQ: begin
        branch  = 1'b1;
        imm_src = IMM_B;
        alu_op  = ALUOP_SUB;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        jump       = 1'b1;
        imm_src    = IMM_J;
        result_src = RES_PC4;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign bus.InstrD      = instr_q;
  assign bus.PCD         = pc_q;
  assign bus.PCplus4D    = pc4_q;
  assign bus.RD1D        = rd1;
  assign bus.RD2D        = rd2;
  assign bus.Rs1D        = rs1;
  assign bus.Rs2D        = rs2;
  assign bus.RdD         = rd;
  assign bus.ImmExtD     = imm_gen(instr_q, imm_src);
  // A write to x0 is dropped anyway, so the bubble (addi x0) reports no register write
  assign bus.RegWriteD   = reg_write && (rd != 5'd0);
  assign bus.ResultSrcD  = result_src;
  assign bus.MemWriteD   = mem_write;
  assign bus.JumpD       = jump;
  assign bus.BranchD     = branch;
  assign bus.ALUSrcD     = alu_src;
  assign bus.ALUControlD = alu_dec(alu_op, funct3, opcode[5], instr_q[30]);
  assign bus.IllegalD    = illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vector table plus register-file, stall/flush and reset sequences.
module tb_id_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_stage_if #(.XLEN(32)) bus ();

  id_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        chk_imm;
    logic        regw;
    logic [1:0]  ressrc;
    logic        memw;
    logic        jump;
    logic        branch;
    logic        alusrc;
    logic [2:0]  aluc;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    bus.InstrF   = instr;
    bus.PCF      = pc;
    bus.PCplus4F = pc + 32'd4;
  endtask

  function automatic logic [31:0] ctrl_word();
    return {21'd0, bus.RegWriteD, bus.ResultSrcD, bus.MemWriteD, bus.JumpD,
            bus.BranchD, bus.ALUSrcD, bus.ALUControlD, bus.IllegalD};
  endfunction

  function automatic logic [31:0] exp_ctrl(input vec_t v);
    return {21'd0, v.regw, v.ressrc, v.memw, v.jump, v.branch, v.alusrc, v.aluc, v.ill};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           instr         pc     imm           ci  rw res   mw  j   b   as  aluc    il  rd  rs1 rs2
    vecs[0]  = '{32'h00500093, 32'h04, 32'h00000005, 1, 1, 2'b00, 0, 0, 0, 1, 3'b000, 0, 1,  0,  5};
    vecs[1]  = '{32'hFE000EE3, 32'h08, 32'hFFFFFFFC, 1, 0, 2'b00, 0, 0, 1, 0, 3'b001, 0, 29, 0,  0};
    vecs[2]  = '{32'hFFFFFFFF, 32'h0C, 32'h00000000, 0, 0, 2'b00, 0, 0, 0, 0, 3'b000, 1, 31, 31, 31};
    vecs[3]  = '{32'h402081B3, 32'h10, 32'h00000000, 0, 1, 2'b00, 0, 0, 0, 0, 3'b001, 0, 3,  1,  2};
    vecs[4]  = '{32'h002081B3, 32'h14, 32'h00000000, 0, 1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 3,  1,  2};
    vecs[5]  = '{32'h40000093, 32'h18, 32'h00000400, 1, 1, 2'b00, 0, 0, 0, 1, 3'b000, 0, 1,  0,  0};
    vecs[6]  = '{32'hFFC12283, 32'h1C, 32'hFFFFFFFC, 1, 1, 2'b01, 0, 0, 0, 1, 3'b000, 0, 5,  2,  28};
    vecs[7]  = '{32'h00612423, 32'h20, 32'h00000008, 1, 0, 2'b00, 1, 0, 0, 1, 3'b000, 0, 8,  2,  6};
    vecs[8]  = '{32'hFF9FF0EF, 32'h24, 32'hFFFFFFF8, 1, 1, 2'b10, 0, 1, 0, 0, 3'b000, 0, 1,  31, 25};
    vecs[9]  = '{32'h0020A1B3, 32'h28, 32'h00000000, 0, 1, 2'b00, 0, 0, 0, 0, 3'b101, 0, 3,  1,  2};
    vecs[10] = '{32'h0020E1B3, 32'h2C, 32'h00000000, 0, 1, 2'b00, 0, 0, 0, 0, 3'b011, 0, 3,  1,  2};
    vecs[11] = '{32'h0020F1B3, 32'h30, 32'h00000000, 0, 1, 2'b00, 0, 0, 0, 0, 3'b010, 0, 3,  1,  2};
    vecs[12] = '{32'h0020C1B3, 32'h34, 32'h00000000, 0, 1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 3,  1,  2};
    vecs[13] = '{32'h0FF0F093, 32'h38, 32'h000000FF, 1, 1, 2'b00, 0, 0, 0, 1, 3'b010, 0, 1,  1,  31};
    vecs[14] = '{32'h00000013, 32'h3C, 32'h00000000, 1, 0, 2'b00, 0, 0, 0, 1, 3'b000, 0, 0,  0,  0};

    reset         = 1'b1;
    bus.StallD    = 1'b0;
    bus.FlushD    = 1'b0;
    bus.RegWriteW = 1'b0;
    bus.RdW       = 5'd0;
    bus.ResultW   = 32'd0;
    drive(32'h00500093, 32'h4);
    step();
    step();

    // Reset state
    chk("rst_instr", bus.InstrD, 32'h00000013);
    chk("rst_pc", bus.PCD, 32'h0);
    chk("rst_pc4", bus.PCplus4D, 32'h0);
    chk("rst_regw", {31'd0, bus.RegWriteD}, 32'd0);
    chk("rst_illegal", {31'd0, bus.IllegalD}, 32'd0);
    chk("rst_rd1", bus.RD1D, 32'h0);
    #3 reset = 1'b0;

    // Decode table: each instruction appears in ID one cycle after being presented
    for (int k = 0; k < 15; k++) begin
      drive(vecs[k].instr, vecs[k].pc);
      step();
      chk($sformatf("v%0d_instr", k), bus.InstrD, vecs[k].instr);
      chk($sformatf("v%0d_pc", k), bus.PCD, vecs[k].pc);
      chk($sformatf("v%0d_pc4", k), bus.PCplus4D, vecs[k].pc + 32'd4);
      chk($sformatf("v%0d_ctrl", k), ctrl_word(), exp_ctrl(vecs[k]));
      chk($sformatf("v%0d_regs", k), {17'd0, bus.RdD, bus.Rs1D, bus.Rs2D},
          {17'd0, vecs[k].rd, vecs[k].rs1, vecs[k].rs2});
      if (vecs[k].chk_imm) chk($sformatf("v%0d_imm", k), bus.ImmExtD, vecs[k].imm);
    end

    // Register file: addi x2,x1,0 reads x1 while x1 is written
    drive(32'h00008113, 32'h40);
    step();
    bus.RegWriteW = 1'b1;
    bus.RdW       = 5'd1;
    bus.ResultW   = 32'h000000AA;
    #1;
`ifdef ID_BYPASS_EN
    chk("wr_same_cycle_rd1", bus.RD1D, 32'h000000AA);
`else
    chk("wr_same_cycle_rd1", bus.RD1D, 32'h00000000);
`endif
    step();
    bus.RegWriteW = 1'b0;
    #1;
    chk("wr_next_cycle_rd1", bus.RD1D, 32'h000000AA);

    // Write x2, then read x1/x2 through sub x3,x1,x2
    bus.RegWriteW = 1'b1;
    bus.RdW       = 5'd2;
    bus.ResultW   = 32'h12345678;
    drive(32'h402081B3, 32'h44);
    step();
    bus.RegWriteW = 1'b0;
    #1;
    chk("rf_rd1_x1", bus.RD1D, 32'h000000AA);
    chk("rf_rd2_x2", bus.RD2D, 32'h12345678);

    // Write to x0 is dropped and never bypassed: add x0,x0,x0
    drive(32'h00000033, 32'h48);
    step();
    bus.RegWriteW = 1'b1;
    bus.RdW       = 5'd0;
    bus.ResultW   = 32'h00000055;
    #1;
    chk("x0_same_cycle", bus.RD1D, 32'h0);
    step();
    bus.RegWriteW = 1'b0;
    #1;
    chk("x0_rd1", bus.RD1D, 32'h0);
    chk("x0_rd2", bus.RD2D, 32'h0);

    // Flush beats stall
    drive(32'h00500093, 32'h80);
    bus.StallD = 1'b1;
    bus.FlushD = 1'b1;
    step();
    chk("flush_instr", bus.InstrD, 32'h00000013);
    chk("flush_pc", bus.PCD, 32'h0);
    chk("flush_pc4", bus.PCplus4D, 32'h0);
    bus.StallD = 1'b0;
    bus.FlushD = 1'b0;
    step();
    chk("load_instr", bus.InstrD, 32'h00500093);
    chk("load_pc", bus.PCD, 32'h80);

    // Stall holds for two cycles while fetch presents something else
    drive(32'h0020A1B3, 32'h84);
    bus.StallD = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("stall%0d_instr", c), bus.InstrD, 32'h00500093);
      chk($sformatf("stall%0d_pc", c), bus.PCD, 32'h80);
      chk($sformatf("stall%0d_pc4", c), bus.PCplus4D, 32'h84);
    end
    bus.StallD = 1'b0;
    step();
    chk("unstall_instr", bus.InstrD, 32'h0020A1B3);
    chk("unstall_pc", bus.PCD, 32'h84);

    // Reset asserted between edges takes effect immediately
    drive(32'h402081B3, 32'h90);
    step();
    chk("pre_rst_rd1", bus.RD1D, 32'h000000AA);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_instr", bus.InstrD, 32'h00000013);
    chk("mid_rst_pc", bus.PCD, 32'h0);
    chk("mid_rst_regw", {31'd0, bus.RegWriteD}, 32'd0);
    chk("mid_rst_illegal", {31'd0, bus.IllegalD}, 32'd0);
    #2 reset = 1'b0;
    step();
    chk("post_rst_instr", bus.InstrD, 32'h402081B3);
    chk("post_rst_rd1", bus.RD1D, 32'h0);
    chk("post_rst_rd2", bus.RD2D, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
